pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
Parametrised pipeline stage register replacing the plain load-enabled control-word register between pipeline stages. Carries a WIDTH-bit payload, typically rv32i_control_word packed, plus datapath fields. Uses a valid/ready handshake on both sides with a two-entry skid buffer, so back-pressure never creates a combinational ready path and full throughput is sustained. Adds a synchronous flush for branch/exception squash, an occupancy output, and a saturating transfer counter for performance monitoring.

Parameters:
WIDTH, 32, payload width in bits (set to $bits(rv32i_control_word) for control-word stages)
ZERO_ON_FLUSH, 1, when 1 flush also clears both data registers to 0 (bubble = all-zero control word); when 0 data registers hold their values
CNT_W, 16, width of saturating transfer counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
flush  input  1  synchronous squash of all held entries
in_valid  input  1  upstream presents in_data
in_ready  output  1  stage can accept; registered, depends only on state
in_data  input  WIDTH  upstream payload
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  WIDTH  head entry payload
occupancy  output  2  entries held: 0, 1 or 2
xfer_count  output  CNT_W  number of completed output transfers, saturating

Behaviour:
- Reset (rst low, asynchronous): state EMPTY, main and skid data = 0, xfer_count = 0. Outputs during reset: out_valid=0, in_ready=1, out_data=0, occupancy=0.
- States (pipe_state_e): EMPTY (no entries), ONE (main valid), FULL (main + skid valid).
- out_valid = (state != EMPTY). out_data = main register, always, including when invalid. in_ready = (state != FULL). occupancy = 0/1/2 per state.
- Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
- EMPTY: accept -> main<=in_data, go to ONE.
- ONE: accept & transfer -> main<=in_data, stay ONE. accept & !transfer -> skid<=in_data, go to FULL. !accept & transfer -> go to EMPTY. Otherwise hold.
- FULL: no accept possible. transfer -> main<=skid, go to ONE. Otherwise hold.
- Latency: data accepted at edge N appears on out_data with out_valid=1 after edge N (one cycle). Sustained 1 transfer/cycle when out_ready is held high.
- Ordering is strictly FIFO; no entry is dropped or duplicated except by flush.
- Flush has highest priority: next state EMPTY regardless of in_valid/out_ready. An input presented in the flush cycle is discarded. A transfer completing in the flush cycle still counts (downstream saw it). If ZERO_ON_FLUSH=1, main and skid are cleared to 0; else they hold.
- xfer_count increments by 1 on each transfer. It saturates at all-ones (2^CNT_W-1) and is not wrapped. It is not cleared by flush, only by reset.
- Reset asserted mid-transfer: all state is cleared immediately (asynchronously). The in-flight payload is lost. No output glitches to valid.
- in_data is ignored while in_ready=0. Upstream must hold in_valid/in_data until accept.

Decomposition:
- rv32i_types gains pipe_state_e (EMPTY, ONE, FULL; 2-bit enum). rv32i_control_word remains the payload type there.
- One natural sub-module: sat_counter (params WIDTH; ports clk, rst, inc, count), reused by other perf counters.
- All other logic stays in pipe_skid_reg: state register, two data registers, next-state logic.

Test Plan:
- Reset then idle: rst low 3 cycles, release -> out_valid=0, in_ready=1, occupancy=0, out_data=0, xfer_count=0.
- Streaming: out_ready=1, drive in_data 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 each one cycle later, in_ready stays 1, xfer_count=8.
- Back-pressure: out_ready=0, send 0xA,0xB,0xC with in_valid held -> occupancy 1 then 2, in_ready=0 after 0xB, 0xC held; raise out_ready -> outputs 0xA,0xB,0xC in order, none lost.
- Flush while FULL (ZERO_ON_FLUSH=1) with in_valid=1, in_data=0xD -> next cycle state EMPTY, out_valid=0, out_data=0, 0xD never emitted. With ZERO_ON_FLUSH=0 -> out_data retains prior head value, out_valid=0.
- Saturation: CNT_W=4, 20 transfers -> xfer_count stops at 15; then flush -> still 15; assert rst -> 0.
- Async reset mid-stream: drop rst between clock edges while FULL -> out_valid=0 and occupancy=0 immediately, before next edge.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: control-word payload and pipeline-stage state.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package rv32i_types;

    // Decoded control word carried between pipeline stages.
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
    } rv32i_control_word;

    // Occupancy state of a two-entry skid pipeline register.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    // Number of entries held in a given state.
    function automatic logic [1:0] state_occupancy(pipe_state_e s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance monitoring.
// Latency: count reflects an increment one cycle after inc is sampled.
// Backpressure: none; increments are dropped once the counter is all-ones.
// Ports: clk, rst (async active-low), inc (count one event), count (current value).
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        count_d = count_q;
        // Hold at all-ones rather than wrapping back to zero.
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register with valid/ready on both sides, flush and perf counter.
// Latency: one cycle from accept to out_valid; sustains one transfer per cycle.
// Backpressure: in_ready comes from state flops only; a second entry is absorbed in the skid.
// Ports: clk, rst (async active-low), flush (squash held entries), in_valid/in_ready/in_data
//        (upstream), out_valid/out_ready/out_data (downstream, data = main register),
//        occupancy (0..2 entries), xfer_count (saturating count of output transfers).
module pipe_skid_reg
    import rv32i_types::*;
#(
    parameter int WIDTH         = 32,
    parameter bit ZERO_ON_FLUSH = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] xfer_count
);

    pipe_state_e      state_d;
    pipe_state_e      state_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_d;
    logic [WIDTH-1:0] skid_q;
    logic             accept;
    logic             xfer;

    // Handshake outputs are pure functions of the state register, so there is
    // no combinational path from out_ready back to in_ready.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign out_data  = main_q;
    assign occupancy = state_occupancy(state_q);

    assign accept = in_valid & in_ready;
    assign xfer   = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Squash wins over everything; an input offered this cycle is dropped.
            state_d = EMPTY;
            if (ZERO_ON_FLUSH) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && xfer) begin
                        main_d = in_data;
                    end else if (accept) begin
                        // Downstream stalled: park the new entry behind the head.
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // A transfer in the flush cycle still counts: downstream consumed it.
    sat_counter #(
        .WIDTH(CNT_W)
    ) u_xfer_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (xfer),
        .count(xfer_count)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomised scoreboard bench for pipe_skid_reg: two instances share stimulus,
// one zeroing on flush with a 4-bit counter, one holding data with a 16-bit counter.
module tb_pipe_skid_reg;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;

    logic         in_ready0, in_ready1;
    logic         out_valid0, out_valid1;
    logic [W-1:0] out_data0, out_data1;
    logic [1:0]   occ0, occ1;
    logic [3:0]   cnt0;
    logic [15:0]  cnt1;

    pipe_skid_reg #(.WIDTH(W), .ZERO_ON_FLUSH(1'b1), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .occupancy(occ0), .xfer_count(cnt0)
    );

    pipe_skid_reg #(.WIDTH(W), .ZERO_ON_FLUSH(1'b0), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occ1), .xfer_count(cnt1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Entries held are a FIFO; occ_m counts them. The visible payload when empty
    // is whatever the head last was (or zero after a zeroing flush).
    int           occ_m;
    logic [W-1:0] sb_q[$];
    logic [W-1:0] main0_m, main1_m;
    int           cnt0_m, cnt1_m;
    bit           acc_seen;
    bit           m_acc, m_xf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_m    = 0;
            sb_q.delete();
            main0_m  = '0;
            main1_m  = '0;
            cnt0_m   = 0;
            cnt1_m   = 0;
            acc_seen = 1'b0;
        end else begin
            m_acc    = in_valid && (occ_m < 2);
            m_xf     = (occ_m > 0) && out_ready;
            acc_seen = m_acc;
            if (m_xf) begin
                cnt0_m = (cnt0_m < 15) ? cnt0_m + 1 : 15;
                cnt1_m = (cnt1_m < 65535) ? cnt1_m + 1 : 65535;
            end
            if (flush) begin
                occ_m = 0;
                sb_q.delete();
                main0_m = '0;
            end else begin
                occ_m = occ_m + int'(m_acc) - int'(m_xf);
                if (m_acc) sb_q.push_back(in_data);
            end
            if (occ_m > 0) begin
                main0_m = sb_q[0];
                main1_m = sb_q[0];
            end
        end
    end

    // ---------------- monitor ----------------
    logic [W-1:0] exp_d;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid0", out_valid0, occ_m != 0);
            chk("valid1", out_valid1, occ_m != 0);
            chk("in_ready0", in_ready0, occ_m < 2);
            chk("in_ready1", in_ready1, occ_m < 2);
            chk("occ0", occ0, occ_m);
            chk("occ1", occ1, occ_m);
            chk("cnt0", cnt0, cnt0_m);
            chk("cnt1", cnt1, cnt1_m);
            if (occ_m == 0) begin
                chk("idle_data0", out_data0, main0_m);
                chk("idle_data1", out_data1, main1_m);
            end
            if (out_valid0 && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got %0h, expected no output", out_data0);
                end else begin
                    exp_d = sb_q.pop_front();
                    chk("xfer_data0", out_data0, exp_d);
                    chk("xfer_data1", out_data1, exp_d);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    bit flush_prev;

    initial begin
        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid0, 1'b0);
        chk("rst_ready", in_ready0, 1'b1);
        chk("rst_occ", occ0, 2'd0);
        chk("rst_data", out_data0, 32'h0);
        chk("rst_cnt", cnt1, 16'h0);
        rst_n = 1'b1;
        step();

        // Streaming 1..8 at full rate.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        chk("stream_cnt", cnt1, 16'd8);

        // Back-pressure: A, B fill both entries, C is held off.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA; step();
        in_data   = 32'hB; step();
        chk("bp_ready_low", in_ready0, 1'b0);
        in_data   = 32'hC; step();
        step();
        chk("bp_occ2", occ0, 2'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 10 && !acc_seen; k++) step();
        chk("bp_c_accepted", acc_seen, 1'b1);
        in_valid = 1'b0;
        repeat (4) step();

        // Flush while FULL with a live input that must be dropped.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11; step();
        in_data   = 32'h22; step();
        in_data   = 32'hD;
        flush     = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid0", out_valid0, 1'b0);
        chk("flush_valid1", out_valid1, 1'b0);
        chk("flush_data0", out_data0, 32'h0);
        chk("flush_data1", out_data1, 32'h11);
        out_ready = 1'b1;
        repeat (3) step();

        // Random traffic with occasional flushes; upstream holds until accepted.
        flush_prev = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (!(in_valid && !acc_seen && !flush_prev)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = $urandom;
            end
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 24) == 0);
            flush_prev = flush;
            step();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("sat_cnt0", cnt0, 4'hF);

        // Flush does not clear the counter.
        flush = 1'b1; step();
        flush = 1'b0; step();
        chk("sat_after_flush", cnt0, 4'hF);

        // Async reset between edges while FULL.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55; step();
        in_data   = 32'h66; step();
        in_valid  = 1'b0;
        chk("pre_rst_occ", occ0, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid0", out_valid0, 1'b0);
        chk("arst_valid1", out_valid1, 1'b0);
        chk("arst_occ", occ0, 2'd0);
        chk("arst_ready", in_ready1, 1'b1);
        chk("arst_data1", out_data1, 32'h0);
        chk("arst_cnt0", cnt0, 4'h0);
        chk("arst_cnt1", cnt1, 16'h0);
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
